phold_lp_core: RTL and testbench

- One PHOLD logical-process execution core; four instances sit in the PHOLD scheduler between the event dispatch/receive arbiters and the shared memory-controller (MC) arbiter.
- Accepts one event (LP id, timestamp) and does a read-modify-write of that LP's state word in host memory.
- Then emits one new event, with a random target and a random future timestamp, and holds it until acknowledged.

---
 rtl/phold_lp_core.sv | 152 +++++++++++++++
 tb/tb_phold_lp_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phold_lp_core.sv
// PHOLD logical-process core: one event in, read-modify-write of the LP state word,
// one generated event out, held until acknowledged.
module phold_lp_core #(
   parameter int unsigned NUM_MEM_BYTE    = 16,
   parameter int unsigned MC_RTNCTL_WIDTH = 32,
   parameter int unsigned TIME_WID        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 core_id,
   input  logic                       event_valid,
   input  logic [2:0]                 event_id,
   input  logic [TIME_WID-1:0]        event_time,
   input  logic [TIME_WID-1:0]        global_time,
   input  logic [7:0]                 random_in,
   output logic [TIME_WID-1:0]        new_event_time,
   output logic [2:0]                 new_event_target,
   output logic                       new_event_ready,
   output logic                       ready,
   input  logic                       ack,
   output logic                       mc_rq_vld,
   output logic [2:0]                 mc_rq_cmd,
   output logic [3:0]                 mc_rq_scmd,
   output logic [47:0]                mc_rq_vadr,
   output logic [1:0]                 mc_rq_size,
   output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
   output logic [63:0]                mc_rq_data,
   output logic                       mc_rq_flush,
   input  logic                       mc_rq_stall,
   input  logic                       mc_rs_vld,
   input  logic [2:0]                 mc_rs_cmd,
   input  logic [3:0]                 mc_rs_scmd,
   input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
   input  logic [63:0]                mc_rs_data,
   output logic                       mc_rs_stall,
   input  logic [47:0]                addr,
   input  logic                       mem_gnt
);

   localparam int unsigned CNT_W = 64 - TIME_WID;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      SEND    = 3'd5
   } state_t;

   state_t                       state_q, state_d;
   logic [TIME_WID-1:0]          t_q, t_d;
   logic [47:0]                  vadr_q, vadr_d;
   logic [63:0]                  wdata_q, wdata_d;
   logic [2:0]                   tgt_q, tgt_d;
   logic [TIME_WID-1:0]          ntime_q, ntime_d;
   logic [MC_RTNCTL_WIDTH-1:0]   rtnctl_q, rtnctl_d;
   logic                         ready_q, ready_d;
   logic                         nev_rdy_q, nev_rdy_d;
   logic                         rq_vld_q, rq_vld_d;
   logic [2:0]                   rq_cmd_q, rq_cmd_d;

   logic rq_accept;
   logic rs_match;
   logic unused_ok;

   assign rq_accept = rq_vld_q & mem_gnt & ~mc_rq_stall;
   assign rs_match  = mc_rs_vld && (mc_rs_rtnctl[1:0] == core_id);
   assign unused_ok = ^{global_time, mc_rs_scmd, mc_rs_rtnctl[MC_RTNCTL_WIDTH-1:2],
                        mc_rs_data[TIME_WID-1:0]};

   // Next state, latched event context and next registered outputs
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      vadr_d   = vadr_q;
      wdata_d  = wdata_q;
      tgt_d    = tgt_q;
      ntime_d  = ntime_q;
      rtnctl_d = rtnctl_q;
      case (state_q)
         IDLE: begin
            if (event_valid) begin
               state_d  = RD_REQ;
               t_d      = event_time;
               vadr_d   = addr + 48'(event_id) * 48'(NUM_MEM_BYTE);
               tgt_d    = random_in[7:5];
               ntime_d  = event_time + TIME_WID'(1) + TIME_WID'(random_in[4:0]);
               rtnctl_d = MC_RTNCTL_WIDTH'(core_id);
            end
         end
         RD_REQ:  if (rq_accept) state_d = RD_WAIT;
         RD_WAIT: begin
            if (rs_match && (mc_rs_cmd == 3'd2)) begin
               state_d = WR_REQ;
               wdata_d = {mc_rs_data[63:TIME_WID] + CNT_W'(1), t_q};
            end
         end
         WR_REQ:  if (rq_accept) state_d = WR_WAIT;
         WR_WAIT: if (rs_match && (mc_rs_cmd == 3'd3)) state_d = SEND;
         SEND:    if (ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d   = (state_d == IDLE);
      nev_rdy_d = (state_d == SEND);
      rq_vld_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
      rq_cmd_d  = (state_d == RD_REQ) ? 3'd1 : ((state_d == WR_REQ) ? 3'd2 : 3'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         t_q       <= '0;
         vadr_q    <= '0;
         wdata_q   <= '0;
         tgt_q     <= '0;
         ntime_q   <= '0;
         rtnctl_q  <= '0;
         ready_q   <= 1'b1;
         nev_rdy_q <= 1'b0;
         rq_vld_q  <= 1'b0;
         rq_cmd_q  <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         vadr_q    <= vadr_d;
         wdata_q   <= wdata_d;
         tgt_q     <= tgt_d;
         ntime_q   <= ntime_d;
         rtnctl_q  <= rtnctl_d;
         ready_q   <= ready_d;
         nev_rdy_q <= nev_rdy_d;
         rq_vld_q  <= rq_vld_d;
         rq_cmd_q  <= rq_cmd_d;
      end
   end

   assign ready            = ready_q;
   assign new_event_ready  = nev_rdy_q;
   assign new_event_target = tgt_q;
   assign new_event_time   = ntime_q;
   assign mc_rq_vld        = rq_vld_q;
   assign mc_rq_cmd        = rq_cmd_q;
   assign mc_rq_vadr       = vadr_q;
   assign mc_rq_data       = wdata_q;
   assign mc_rq_rtnctl     = rtnctl_q;
   assign mc_rq_scmd       = 4'd0;
   assign mc_rq_size       = 2'd3;
   assign mc_rq_flush      = 1'b0;
   assign mc_rs_stall      = 1'b0;

endmodule

// File: tb/tb_phold_lp_core.sv
// Bench for phold_lp_core: directed vector table, reset corner case and
// randomized events scored against a per-LP memory model.
module tb_phold_lp_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  core_id;
   logic        event_valid;
   logic [2:0]  event_id;
   logic [15:0] event_time;
   logic [15:0] global_time;
   logic [7:0]  random_in;
   logic [15:0] new_event_time;
   logic [2:0]  new_event_target;
   logic        new_event_ready;
   logic        ready;
   logic        ack;
   logic        mc_rq_vld;
   logic [2:0]  mc_rq_cmd;
   logic [3:0]  mc_rq_scmd;
   logic [47:0] mc_rq_vadr;
   logic [1:0]  mc_rq_size;
   logic [31:0] mc_rq_rtnctl;
   logic [63:0] mc_rq_data;
   logic        mc_rq_flush;
   logic        mc_rq_stall;
   logic        mc_rs_vld;
   logic [2:0]  mc_rs_cmd;
   logic [3:0]  mc_rs_scmd;
   logic [31:0] mc_rs_rtnctl;
   logic [63:0] mc_rs_data;
   logic        mc_rs_stall;
   logic [47:0] addr;
   logic        mem_gnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   phold_lp_core #(.NUM_MEM_BYTE(16), .MC_RTNCTL_WIDTH(32), .TIME_WID(16)) dut (
      .clk(clk), .rst(rst), .core_id(core_id), .event_valid(event_valid),
      .event_id(event_id), .event_time(event_time), .global_time(global_time),
      .random_in(random_in), .new_event_time(new_event_time),
      .new_event_target(new_event_target), .new_event_ready(new_event_ready),
      .ready(ready), .ack(ack), .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd),
      .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size),
      .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush),
      .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
      .mc_rs_scmd(mc_rs_scmd), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data),
      .mc_rs_stall(mc_rs_stall), .addr(addr), .mem_gnt(mem_gnt)
   );

   typedef struct {
      logic [2:0]  id;
      logic [15:0] t;
      logic [7:0]  r;
      logic [47:0] base;
      logic [1:0]  core;
      logic [63:0] rdata;
      logic [47:0] vadr;
      logic [63:0] wdata;
      logic [2:0]  tgt;
      logic [15:0] ntime;
      int          gw;
      int          rw;
      int          aw;
   } vec_t;

   vec_t        tbl[4];
   logic [63:0] mem_model[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_rs(input logic [2:0] cmd, input logic [1:0] tag, input logic [63:0] data);
      mc_rs_vld    = 1'b1;
      mc_rs_cmd    = cmd;
      mc_rs_rtnctl = {30'($urandom), tag};
      mc_rs_data   = data;
      tick();
      mc_rs_vld    = 1'b0;
      mc_rs_data   = 64'($urandom);
   endtask

   // Full event lifecycle with hold-offs: gw blocked request cycles, rw foreign
   // responses and aw cycles of withheld ack.
   task automatic run_event(input logic [2:0] id, input logic [15:0] t, input logic [7:0] r,
                            input logic [47:0] base, input logic [1:0] core,
                            input logic [63:0] rdata, input logic [47:0] ex_vadr,
                            input logic [63:0] ex_wdata, input logic [2:0] ex_tgt,
                            input logic [15:0] ex_time, input int gw, input int rw,
                            input int aw);
      core_id = core;
      addr    = base;
      chk("ready_idle", 64'(ready), 64'd1);
      event_valid = 1'b1;
      event_id    = id;
      event_time  = t;
      random_in   = r;
      tick();
      event_valid = 1'b0;
      event_id    = 3'($urandom);
      event_time  = 16'($urandom);
      random_in   = 8'($urandom);
      chk("rd_vld", 64'(mc_rq_vld), 64'd1);
      chk("rd_cmd", 64'(mc_rq_cmd), 64'd1);
      chk("rd_vadr", 64'(mc_rq_vadr), 64'(ex_vadr));
      chk("rd_rtnctl", 64'(mc_rq_rtnctl), 64'(core));
      chk("ready_busy", 64'(ready), 64'd0);
      for (int i = 0; i < gw; i++) begin
         mem_gnt     = (i % 2) == 1;
         mc_rq_stall = (i % 2) == 1;
         tick();
         chk("rd_hold_vld", 64'(mc_rq_vld), 64'd1);
         chk("rd_hold_vadr", 64'(mc_rq_vadr), 64'(ex_vadr));
         chk("rd_hold_cmd", 64'(mc_rq_cmd), 64'd1);
      end
      mem_gnt     = 1'b1;
      mc_rq_stall = 1'b0;
      tick();
      mem_gnt = 1'b0;
      chk("rd_accepted", 64'(mc_rq_vld), 64'd0);
      for (int i = 0; i < rw; i++) begin
         send_rs(3'd2, core + 2'd1 + 2'(i % 3), 64'($urandom));
         chk("foreign_rs_vld", 64'(mc_rq_vld), 64'd0);
         chk("foreign_rs_nev", 64'(new_event_ready), 64'd0);
      end
      send_rs(3'd2, core, rdata);
      chk("wr_vld", 64'(mc_rq_vld), 64'd1);
      chk("wr_cmd", 64'(mc_rq_cmd), 64'd2);
      chk("wr_vadr", 64'(mc_rq_vadr), 64'(ex_vadr));
      chk("wr_data", mc_rq_data, ex_wdata);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wr_accepted", 64'(mc_rq_vld), 64'd0);
      send_rs(3'd3, core, 64'd0);
      chk("send_nev", 64'(new_event_ready), 64'd1);
      chk("send_tgt", 64'(new_event_target), 64'(ex_tgt));
      chk("send_time", 64'(new_event_time), 64'(ex_time));
      for (int i = 0; i < aw; i++) begin
         event_valid = 1'b1;
         tick();
         chk("hold_nev", 64'(new_event_ready), 64'd1);
         chk("hold_time", 64'(new_event_time), 64'(ex_time));
         chk("hold_tgt", 64'(new_event_target), 64'(ex_tgt));
         chk("hold_ready", 64'(ready), 64'd0);
      end
      event_valid = 1'b0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("post_ack_nev", 64'(new_event_ready), 64'd0);
      chk("post_ack_ready", 64'(ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  id;
      logic [15:0] t;
      logic [7:0]  r;
      logic [47:0] base;
      logic [1:0]  core;
      logic [63:0] rdata;
      logic [47:0] ex_vadr;
      logic [63:0] ex_wdata;
      longint unsigned cnt;
      int unsigned     tsum;

      rst = 1'b1; core_id = 2'd1; event_valid = 1'b0; event_id = '0; event_time = '0;
      global_time = '0; random_in = '0; ack = 1'b0; mc_rq_stall = 1'b0; mc_rs_vld = 1'b0;
      mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_rtnctl = '0; mc_rs_data = '0; addr = '0;
      mem_gnt = 1'b0;

      tbl[0] = '{3'd2, 16'd100, 8'hA3, 48'h1000, 2'd1, 64'h0000_0000_0005_0000,
                 48'h1020, 64'h0000_0000_0006_0064, 3'd5, 16'd104, 5, 1, 10};
      tbl[1] = '{3'd0, 16'hFFFE, 8'h1F, 48'h0, 2'd1, 64'h0,
                 48'h0, 64'h0000_0000_0001_FFFE, 3'd0, 16'h001E, 0, 0, 0};
      tbl[2] = '{3'd7, 16'h1234, 8'hFF, 48'hFFFF_FFFF_FFF0, 2'd1, 64'hFFFF_FFFF_FFFF_ABCD,
                 48'h60, 64'h0000_0000_0000_1234, 3'd7, 16'h1254, 2, 2, 1};
      tbl[3] = '{3'd5, 16'h0000, 8'h40, 48'hABC0, 2'd2, 64'h1234_5678_9ABC_DEF0,
                 48'hAC10, 64'h1234_5678_9ABD_0000, 3'd2, 16'h0001, 1, 3, 2};

      tick(); tick();
      rst = 1'b0;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_nev", 64'(new_event_ready), 64'd0);
      chk("rst_vld", 64'(mc_rq_vld), 64'd0);
      chk("rst_time", 64'(new_event_time), 64'd0);
      chk("rst_vadr", 64'(mc_rq_vadr), 64'd0);
      chk("const_size", 64'(mc_rq_size), 64'd3);
      chk("const_rs_stall", 64'(mc_rs_stall), 64'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("idle_ack_ignored", 64'(ready), 64'd1);

      for (int k = 0; k < 4; k++)
         run_event(tbl[k].id, tbl[k].t, tbl[k].r, tbl[k].base, tbl[k].core, tbl[k].rdata,
                   tbl[k].vadr, tbl[k].wdata, tbl[k].tgt, tbl[k].ntime,
                   tbl[k].gw, tbl[k].rw, tbl[k].aw);

      // Reset while waiting for read data; a late matching response must be ignored.
      core_id = 2'd1; addr = 48'h2000;
      event_valid = 1'b1; event_id = 3'd3; event_time = 16'd50; random_in = 8'h11;
      tick();
      event_valid = 1'b0;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("rst_seq_rdwait", 64'(mc_rq_vld), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 64'(ready), 64'd1);
      chk("midrst_vld", 64'(mc_rq_vld), 64'd0);
      chk("midrst_time", 64'(new_event_time), 64'd0);
      send_rs(3'd2, 2'd1, 64'h0000_0000_0007_0000);
      chk("stale_rs_ready", 64'(ready), 64'd1);
      chk("stale_rs_vld", 64'(mc_rq_vld), 64'd0);
      send_rs(3'd3, 2'd1, 64'h0);
      chk("stale_wr_nev", 64'(new_event_ready), 64'd0);

      // Randomized events against a per-LP state-word model.
      for (int i = 0; i < 8; i++) mem_model[i] = {32'($urandom), 32'($urandom)};
      for (int k = 0; k < 40; k++) begin
         id    = 3'($urandom);
         t     = 16'($urandom);
         r     = 8'($urandom);
         base  = {16'($urandom), 32'($urandom)};
         core  = 2'($urandom);
         rdata = mem_model[id];
         ex_vadr = base + 48'(id) * 48'd16;
         cnt   = ((rdata >> 16) + 1) & 64'hFFFF_FFFF_FFFF;
         ex_wdata = (cnt << 16) | 64'(t);
         tsum  = (32'(t) + 32'd1 + 32'(r % 8'd32)) % 32'd65536;
         run_event(id, t, r, base, core, rdata, ex_vadr, ex_wdata, 3'(r / 8'd32),
                   16'(tsum), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2));
         mem_model[id] = ex_wdata;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
